// File: rtl/core_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, PC/RD mux codes, RV32I opcodes.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_MEM = 2'd1,
    RD_PC4 = 2'd2,
    RD_IMM = 2'd3
  } rd_sel_e;

  localparam int unsigned OPC_W = 5;

  // instr[6:2] major opcodes
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;

  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_wait_tmr.sv
// Memory-wait timeout counter: cleared on state entry, counts stalled request cycles.
module core_seq_wait_tmr #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One more stalled cycle from here reaches TMO_MAX; the FSM gates this with ack.
  assign expired_o = (cnt_q == TMO_W'(TMO_MAX - 1));

endmodule

// File: rtl/core_seq.sv
// RV32I multi-cycle sequencer: FSM, datapath enable decode, sticky trap flags, retire count.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             b,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_wr,
  output logic [1:0]       rd_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [31:0]      retired
);

  state_e      state_q, state_d;
  logic        illegal_q, bus_err_q;
  logic [31:0] retired_q;
  logic        tmo_inc, tmo_clr, tmo_exp;
  logic        retire, set_ill, set_berr;

  assign tmo_clr = (state_d != state_q);

  core_seq_wait_tmr #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_wait_tmr (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (tmo_clr),
    .inc_i     (tmo_inc),
    .expired_o (tmo_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_ill)  illegal_q <= 1'b1;
      if (set_berr) bus_err_q <= 1'b1;
      if (retire)   retired_q <= retired_q + 32'd1;
    end
  end

  // Next state and datapath enables; outputs follow state so reset drops them at once.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    we       = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    reg_wr   = 1'b0;
    rd_sel   = RD_ALU;
    tmo_inc  = 1'b0;
    retire   = 1'b0;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_exp) begin
            state_d  = ST_TRAP;
            set_berr = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (opc_legal(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          set_ill = 1'b1;
        end
      end
      ST_EXEC: begin
        if (opcode == OPC_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = b ? PC_BRANCH : PC_PLUS4;
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        we       = (opcode == OPC_STORE);
        if (dmem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          tmo_inc = 1'b1;
          if (tmo_exp) begin
            state_d  = ST_TRAP;
            set_berr = 1'b1;
          end
        end
      end
      ST_WB: begin
        reg_wr  = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        retire  = 1'b1;
        case (opcode)
          OPC_LOAD:          rd_sel = RD_MEM;
          OPC_LUI:           rd_sel = RD_IMM;
          OPC_JAL, OPC_JALR: rd_sel = RD_PC4;
          default:           rd_sel = RD_ALU;
        endcase
        case (opcode)
          OPC_JAL:  pc_sel = PC_JAL;
          OPC_JALR: pc_sel = PC_JALR;
          default:  pc_sel = PC_PLUS4;
        endcase
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: instruction classes, timeout boundary, illegal trap, async reset.
module tb_core_seq;

  logic        clk, rst;
  logic [4:0]  opcode;
  logic        b, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, we, ir_we, pc_we, reg_wr, illegal, bus_err;
  logic [1:0]  pc_sel, rd_sel;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [9:0] C_IMEM = 10'b10_0000_0000;
  localparam logic [9:0] C_DMEM = 10'b01_0000_0000;
  localparam logic [9:0] C_WE   = 10'b00_1000_0000;
  localparam logic [9:0] C_IR   = 10'b00_0100_0000;
  localparam logic [9:0] C_PCWE = 10'b00_0010_0000;
  localparam logic [9:0] C_REG  = 10'b00_0000_0100;
  localparam logic [9:0] P_BR   = 10'b00_0000_1000;
  localparam logic [9:0] P_JAL  = 10'b00_0001_0000;
  localparam logic [9:0] P_JALR = 10'b00_0001_1000;
  localparam logic [9:0] R_MEM  = 10'b00_0000_0001;
  localparam logic [9:0] R_PC4  = 10'b00_0000_0010;
  localparam logic [9:0] R_IMM  = 10'b00_0000_0011;

  localparam logic [4:0] O_LOAD = 5'b00000, O_OPIMM = 5'b00100, O_STORE = 5'b01000;
  localparam logic [4:0] O_LUI = 5'b01101, O_BR = 5'b11000, O_JAL = 5'b11011, O_BAD = 5'b11111;

  core_seq dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .b        (b),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .imem_req (imem_req),
    .dmem_req (dmem_req),
    .we       (we),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .reg_wr   (reg_wr),
    .rd_sel   (rd_sel),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [9:0] exp);
    #1;
    chk(tag, 32'({imem_req, dmem_req, we, ir_we, pc_we, pc_sel, reg_wr, rd_sel}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the enables of the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [9:0] exp);
    chk_ctl(tag, exp);
    tick();
  endtask

  initial begin
    rst = 1'b0; opcode = '0; b = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) tick();
    chk_ctl("reset_ctl", 10'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_flags", 32'({illegal, bus_err}), 32'd0);
    rst = 1'b1;

    // ADDI with immediate ack
    imem_ack = 1'b1;
    cyc("addi_idle", 10'd0);
    opcode = O_OPIMM;
    cyc("addi_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("addi_decode", 10'd0);
    cyc("addi_exec", 10'd0);
    cyc("addi_wb", C_REG | C_PCWE);
    chk("addi_retired", retired, 32'd1);

    // BEQ taken then not taken
    imem_ack = 1'b1; opcode = O_BR;
    cyc("beq_t_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("beq_t_decode", 10'd0);
    b = 1'b1;
    cyc("beq_t_exec", C_PCWE | P_BR);
    chk("beq_t_retired", retired, 32'd2);
    imem_ack = 1'b1; b = 1'b0;
    cyc("beq_n_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("beq_n_decode", 10'd0);
    cyc("beq_n_exec", C_PCWE);
    chk("beq_n_retired", retired, 32'd3);

    // LW with dmem_ack after 3 wait cycles
    imem_ack = 1'b1; opcode = O_LOAD;
    cyc("lw_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("lw_decode", 10'd0);
    cyc("lw_exec", 10'd0);
    cyc("lw_mem0", C_DMEM);
    cyc("lw_mem1", C_DMEM);
    cyc("lw_mem2", C_DMEM);
    dmem_ack = 1'b1;
    cyc("lw_mem_ack", C_DMEM);
    dmem_ack = 1'b0;
    cyc("lw_wb", C_REG | C_PCWE | R_MEM);
    chk("lw_retired", retired, 32'd4);

    // SW with a spurious dmem_ack held through DECODE/EXEC
    cyc("sw_fetch_wait", C_IMEM);
    imem_ack = 1'b1; opcode = O_STORE;
    cyc("sw_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0; dmem_ack = 1'b1;
    cyc("sw_decode", 10'd0);
    cyc("sw_exec", 10'd0);
    cyc("sw_mem", C_DMEM | C_WE | C_PCWE);
    dmem_ack = 1'b0;
    chk("sw_retired", retired, 32'd5);

    // JAL and LUI writeback selects
    imem_ack = 1'b1; opcode = O_JAL;
    cyc("jal_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("jal_decode", 10'd0);
    cyc("jal_exec", 10'd0);
    cyc("jal_wb", C_REG | C_PCWE | P_JAL | R_PC4);
    imem_ack = 1'b1; opcode = O_LUI;
    cyc("lui_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("lui_decode", 10'd0);
    cyc("lui_exec", 10'd0);
    cyc("lui_wb", C_REG | C_PCWE | R_IMM);
    chk("lui_retired", retired, 32'd7);

    // Fetch ack arrives on the 200th requesting cycle: no error
    repeat (199) tick();
    chk_ctl("tmo_edge_wait", C_IMEM);
    chk("tmo_edge_berr", 32'(bus_err), 32'd0);
    imem_ack = 1'b1; opcode = 5'b00110 ^ 5'b00010;
    cyc("tmo_edge_ack", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("tmo_edge_decode", 10'd0);
    cyc("tmo_edge_exec", 10'd0);
    cyc("tmo_edge_wb", C_REG | C_PCWE);
    chk("tmo_edge_retired", retired, 32'd8);

    // Ack never arrives: trap with bus_err after 200 wait cycles
    repeat (199) tick();
    chk_ctl("tmo_199", C_IMEM);
    tick();
    chk_ctl("tmo_trap_ctl", 10'd0);
    chk("tmo_berr", 32'({illegal, bus_err}), 32'd1);
    imem_ack = 1'b1;
    repeat (3) tick();
    chk_ctl("tmo_trap_hold", 10'd0);
    chk("tmo_trap_retired", retired, 32'd8);
    imem_ack = 1'b0;

    // Reset pulse clears the trap; then an illegal opcode traps
    rst = 1'b0;
    #1;
    chk("rst2_flags", 32'({illegal, bus_err}), 32'd0);
    chk("rst2_retired", retired, 32'd0);
    tick();
    rst = 1'b1;
    imem_ack = 1'b1; opcode = O_BAD;
    cyc("ill_idle", 10'd0);
    cyc("ill_fetch", C_IMEM | C_IR);
    cyc("ill_decode", 10'd0);
    chk("ill_flags", 32'({illegal, bus_err}), 32'd2);
    repeat (3) cyc("ill_trap", 10'd0);
    imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("ill_rst_flags", 32'({illegal, bus_err}), 32'd0);
    tick();
    rst = 1'b1;

    // One ADDI, then reset asserted during the MEM cycle of a store
    imem_ack = 1'b1; opcode = O_OPIMM;
    cyc("r6_idle", 10'd0);
    cyc("r6_addi_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("r6_addi_decode", 10'd0);
    cyc("r6_addi_exec", 10'd0);
    cyc("r6_addi_wb", C_REG | C_PCWE);
    chk("r6_retired1", retired, 32'd1);
    imem_ack = 1'b1; opcode = O_STORE;
    cyc("r6_sw_fetch", C_IMEM | C_IR);
    imem_ack = 1'b0;
    cyc("r6_sw_decode", 10'd0);
    cyc("r6_sw_exec", 10'd0);
    chk_ctl("r6_sw_mem", C_DMEM | C_WE);
    rst = 1'b0;
    chk_ctl("r6_async_drop", 10'd0);
    chk("r6_retired0", retired, 32'd0);
    tick();
    rst = 1'b1;
    cyc("r6_post_idle", 10'd0);
    cyc("r6_post_fetch", C_IMEM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
